// File: rtl/vx_tex_dcr_master_if.sv
// Texture DCR types/addresses and the DCR write bus shared by initiator and tex slave.
// The bus is write-only with no backpressure.
package vx_tex_pkg;
  localparam int DCR_ADDR_WIDTH  = 12;
  localparam int TEX_LOD_MAX     = 3;
  localparam int TEX_LOD_BITS    = 4;
  localparam int TEX_ADDR_BITS   = 32;
  localparam int TEX_FORMAT_BITS = 3;
  localparam int TEX_FILTER_BITS = 2;
  localparam int TEX_WRAP_BITS   = 2;
  localparam int TEX_MIPOFF_BITS = 20;
  localparam int TEX_DCR_ITEMS   = 6 + TEX_LOD_MAX + 1;

  localparam logic [DCR_ADDR_WIDTH-1:0] DCR_TEX_STAGE   = 12'h0C0;
  localparam logic [DCR_ADDR_WIDTH-1:0] DCR_TEX_ADDR    = 12'h0C1;
  localparam logic [DCR_ADDR_WIDTH-1:0] DCR_TEX_FORMAT  = 12'h0C2;
  localparam logic [DCR_ADDR_WIDTH-1:0] DCR_TEX_FILTER  = 12'h0C3;
  localparam logic [DCR_ADDR_WIDTH-1:0] DCR_TEX_WRAP    = 12'h0C4;
  localparam logic [DCR_ADDR_WIDTH-1:0] DCR_TEX_LOGDIM  = 12'h0C5;
  localparam logic [DCR_ADDR_WIDTH-1:0] DCR_TEX_MIPOFF0 = 12'h0C6;

  function automatic logic [DCR_ADDR_WIDTH-1:0] dcr_tex_mipoff(int j);
    return DCR_TEX_MIPOFF0 + DCR_ADDR_WIDTH'(j);
  endfunction

  typedef struct packed {
    logic [TEX_ADDR_BITS-1:0]                   baseaddr;
    logic [TEX_FORMAT_BITS-1:0]                 format;
    logic [TEX_FILTER_BITS-1:0]                 filter;
    logic [1:0][TEX_WRAP_BITS-1:0]              wraps;
    logic [1:0][TEX_LOD_BITS-1:0]               logdims;
    logic [TEX_LOD_MAX:0][TEX_MIPOFF_BITS-1:0]  mipoff;
  } tex_dcrs_t;
endpackage

interface vx_dcr_bus_if;
  logic                                  write_valid;
  logic [vx_tex_pkg::DCR_ADDR_WIDTH-1:0] write_addr;
  logic [31:0]                           write_data;

  modport master (output write_valid, write_addr, write_data);
  modport slave  (input  write_valid, write_addr, write_data);
endinterface

// File: rtl/vx_tex_dcr_master.sv
// Serialises a texture stage descriptor into DCR writes, skipping registers whose
// value already matches the per-stage shadow copy.
module vx_tex_dcr_master import vx_tex_pkg::*; #(
  parameter string INSTANCE_ID = "",
  parameter int    NUM_STAGES  = 1,
  parameter int    GAP_CYCLES  = 0,
  localparam int   STAGE_W     = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [STAGE_W-1:0] req_stage,
  input  tex_dcrs_t          req_dcrs,
  input  logic               req_force,
  output logic               busy,
  output logic               done,
  vx_dcr_bus_if.master       dcr_bus_if
);
  localparam int N     = TEX_DCR_ITEMS;
  localparam int NSLOT = 1 << STAGE_W;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  function automatic logic [N-1:0][DCR_ADDR_WIDTH-1:0] item_addrs();
    logic [N-1:0][DCR_ADDR_WIDTH-1:0] a;
    a[0] = DCR_TEX_STAGE;
    a[1] = DCR_TEX_ADDR;
    a[2] = DCR_TEX_FORMAT;
    a[3] = DCR_TEX_FILTER;
    a[4] = DCR_TEX_WRAP;
    a[5] = DCR_TEX_LOGDIM;
    for (int j = 0; j <= TEX_LOD_MAX; j++) a[6+j] = dcr_tex_mipoff(j);
    return a;
  endfunction
  localparam logic [N-1:0][DCR_ADDR_WIDTH-1:0] ITEM_ADDR = item_addrs();

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, FIN} state_t;

  state_t                    state, state_n;
  logic [N-1:0]              mask, mask_n, dirty, pick;
  logic                      issue;
  logic [STAGE_W-1:0]        stage_q, cur_stage;
  logic                      cur_stage_valid;
  tex_dcrs_t                 dcrs_q;
  tex_dcrs_t                 shadow [NSLOT];
  logic [NSLOT-1:0]          shadow_valid;
  logic [GAP_W-1:0]          gap_cnt;
  logic                      wr_valid_q;
  logic [DCR_ADDR_WIDTH-1:0] wr_addr_q, sel_addr;
  logic [31:0]               wr_data_q, sel_data;

  // Packed register images: 0 = incoming request, 1 = shadow of the requested stage,
  // 2 = latched descriptor being issued.
  tex_dcrs_t              src [3];
  logic [2:0][N-1:0][31:0] pk;

  assign src[0] = req_dcrs;
  assign src[1] = shadow[req_stage];
  assign src[2] = dcrs_q;

  for (genvar s = 0; s < 3; s++) begin : g_pack
    if (s == 2) begin : g_stg
      assign pk[s][0] = 32'(stage_q);
    end else begin : g_nostg
      assign pk[s][0] = '0;
    end
    assign pk[s][1] = 32'(src[s].baseaddr);
    assign pk[s][2] = 32'(src[s].format);
    assign pk[s][3] = 32'(src[s].filter);
    assign pk[s][4] = {{(16-TEX_WRAP_BITS){1'b0}}, src[s].wraps[1],
                       {(16-TEX_WRAP_BITS){1'b0}}, src[s].wraps[0]};
    assign pk[s][5] = {{(16-TEX_LOD_BITS){1'b0}}, src[s].logdims[1],
                       {(16-TEX_LOD_BITS){1'b0}}, src[s].logdims[0]};
    for (genvar j = 0; j <= TEX_LOD_MAX; j++) begin : g_mip
      assign pk[s][6+j] = 32'(src[s].mipoff[j]);
    end
  end

  assign dirty[0] = req_force || !cur_stage_valid || (req_stage != cur_stage);
  for (genvar i = 1; i < N; i++) begin : g_dirty
    assign dirty[i] = req_force || !shadow_valid[req_stage] || (pk[0][i] != pk[1][i]);
  end

  // Lowest pending item wins; clean items never occupy a cycle.
  assign pick = mask & (~mask + N'(1));

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) begin
        sel_addr = ITEM_ADDR[i];
        sel_data = pk[2][i];
      end
    end
  end

  always_comb begin
    state_n = state;
    mask_n  = mask;
    issue   = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        mask_n  = dirty;
        state_n = (|dirty) ? ISSUE : FIN;
      end
      ISSUE: begin
        issue  = 1'b1;
        mask_n = mask & ~pick;
        if (GAP_CYCLES > 0)   state_n = GAP;
        else if (~|mask_n)    state_n = FIN;
      end
      GAP: if (gap_cnt == '0) state_n = (|mask) ? ISSUE : FIN;
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      mask            <= '0;
      gap_cnt         <= '0;
      stage_q         <= '0;
      cur_stage       <= '0;
      cur_stage_valid <= 1'b0;
      shadow_valid    <= '0;
      wr_valid_q      <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      done            <= 1'b0;
    end else begin
      state      <= state_n;
      mask       <= mask_n;
      wr_valid_q <= issue;
      done       <= (state == FIN);
      if (issue) begin
        wr_addr_q <= sel_addr;
        wr_data_q <= sel_data;
        gap_cnt   <= GAP_LOAD;
      end else if (state == GAP) begin
        gap_cnt   <= gap_cnt - GAP_W'(1);
      end
      if (state == IDLE && req_valid) stage_q <= req_stage;
      if (state == FIN) begin
        shadow_valid[stage_q] <= 1'b1;
        cur_stage             <= stage_q;
        cur_stage_valid       <= 1'b1;
      end
    end
  end

  // Data-only storage; validity lives in the reset-cleared bits above.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) dcrs_q <= req_dcrs;
    if (state == FIN) shadow[stage_q] <= dcrs_q;
  end

  assign req_ready              = (state == IDLE) && !reset;
  assign busy                   = (state != IDLE) && !reset;
  assign dcr_bus_if.write_valid = wr_valid_q;
  assign dcr_bus_if.write_addr  = wr_addr_q;
  assign dcr_bus_if.write_data  = wr_data_q;

endmodule

// File: tb/tb_vx_tex_dcr_master.sv
// Drives two initiators (back-to-back and gapped) with the same descriptors and checks
// every cycle against a list-based model of which registers must be rewritten.
module tb_vx_tex_dcr_master;
  import vx_tex_pkg::*;

  localparam int NS = 2;
  localparam int SW = 1;
  localparam int N  = TEX_DCR_ITEMS;
  localparam int G1 = 2;
  localparam int MW = (TEX_LOD_MAX + 1) * TEX_MIPOFF_BITS;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0;
  logic [SW-1:0] req_stage = '0;
  tex_dcrs_t     req_dcrs  = '0;
  logic          req_force = 1'b0;
  logic [1:0]    rdy, bsy, dn, wv;
  logic [1:0][DCR_ADDR_WIDTH-1:0] wa;
  logic [1:0][31:0]               wd;

  vx_dcr_bus_if bus0 ();
  vx_dcr_bus_if bus1 ();

  vx_tex_dcr_master #(.INSTANCE_ID("t0"), .NUM_STAGES(NS), .GAP_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[0]),
    .req_stage(req_stage), .req_dcrs(req_dcrs), .req_force(req_force),
    .busy(bsy[0]), .done(dn[0]), .dcr_bus_if(bus0));

  vx_tex_dcr_master #(.INSTANCE_ID("t1"), .NUM_STAGES(NS), .GAP_CYCLES(G1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(rdy[1]),
    .req_stage(req_stage), .req_dcrs(req_dcrs), .req_force(req_force),
    .busy(bsy[1]), .done(dn[1]), .dcr_bus_if(bus1));

  assign wv[0] = bus0.write_valid;  assign wa[0] = bus0.write_addr;  assign wd[0] = bus0.write_data;
  assign wv[1] = bus1.write_valid;  assign wa[1] = bus1.write_addr;  assign wd[1] = bus1.write_data;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: what the slave currently holds, per stage.
  tex_dcrs_t     m_sh [NS];
  bit            m_sv [NS];
  int            m_cur;
  bit            m_cur_v;
  logic [DCR_ADDR_WIDTH-1:0] ea [$];
  logic [31:0]               ed [$];

  function automatic logic [31:0] fdata(int i, int stg, tex_dcrs_t d);
    logic [MW-1:0] mv;
    mv = d.mipoff;
    case (i)
      0: return 32'(stg);
      1: return 32'(d.baseaddr);
      2: return 32'(d.format);
      3: return 32'(d.filter);
      4: return 32'(d.wraps[0]) + (32'(d.wraps[1]) << 16);
      5: return 32'(d.logdims[0]) + (32'(d.logdims[1]) << 16);
      default: return 32'(mv >> (TEX_MIPOFF_BITS * (i - 6))) & 32'hFFFFF;
    endcase
  endfunction

  function automatic logic [DCR_ADDR_WIDTH-1:0] faddr(int i);
    case (i)
      0: return DCR_TEX_STAGE;
      1: return DCR_TEX_ADDR;
      2: return DCR_TEX_FORMAT;
      3: return DCR_TEX_FILTER;
      4: return DCR_TEX_WRAP;
      5: return DCR_TEX_LOGDIM;
      default: return dcr_tex_mipoff(i - 6);
    endcase
  endfunction

  task automatic build(input int stg, input tex_dcrs_t d, input bit f);
    bit dirty;
    ea.delete();
    ed.delete();
    for (int i = 0; i < N; i++) begin
      if (i == 0) dirty = f || !m_cur_v || (stg != m_cur);
      else        dirty = f || !m_sv[stg] || (fdata(i, stg, d) != fdata(i, stg, m_sh[stg]));
      if (dirty) begin
        ea.push_back(faddr(i));
        ed.push_back(fdata(i, stg, d));
      end
    end
  endtask

  task automatic commit(input int stg, input tex_dcrs_t d);
    m_sh[stg] = d;
    m_sv[stg] = 1'b1;
    m_cur     = stg;
    m_cur_v   = 1'b1;
  endtask

  // Cycle k after the accepting edge: writes land on k = 1 + i*(1+g), done on D*(1+g)+1.
  task automatic watch(input int u, input int g);
    int  d, last, idx;
    bit  ev;
    d    = ea.size();
    last = d * (1 + g) + 1;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      ev  = ((k - 1) % (1 + g) == 0) && ((k - 1) / (1 + g) < d);
      idx = (k - 1) / (1 + g);
      chk($sformatf("u%0d_wvalid_k%0d", u, k), 32'(wv[u]), 32'(ev));
      if (ev) begin
        chk($sformatf("u%0d_waddr_%0d", u, idx), 32'(wa[u]), 32'(ea[idx]));
        chk($sformatf("u%0d_wdata_%0d", u, idx), wd[u], ed[idx]);
      end
      chk($sformatf("u%0d_done_k%0d", u, k),  32'(dn[u]),  32'(k == last));
      chk($sformatf("u%0d_ready_k%0d", u, k), 32'(rdy[u]), 32'(k == last));
      chk($sformatf("u%0d_busy_k%0d", u, k),  32'(bsy[u]), 32'(k != last));
    end
    @(posedge clk); #1;
    chk($sformatf("u%0d_done_drop", u), 32'(dn[u]), 32'd0);
  endtask

  task automatic txn(input int stg, input tex_dcrs_t d, input bit f);
    build(stg, d, f);
    req_stage = SW'(stg);
    req_dcrs  = d;
    req_force = f;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Scramble request inputs; the latched copy must be used.
    req_dcrs  = {$urandom, $urandom, $urandom, $urandom};
    req_stage = ~req_stage;
    req_force = ~f;
    fork
      watch(0, 0);
      watch(1, G1);
    join
    commit(stg, d);
  endtask

  function automatic tex_dcrs_t base_desc();
    tex_dcrs_t     d;
    logic [MW-1:0] mv;
    d = '0;
    d.baseaddr   = 32'h1000;
    d.format     = 3'd2;
    d.filter     = 2'd1;
    d.wraps[0]   = 2'd1;
    d.wraps[1]   = 2'd2;
    d.logdims[0] = 4'd8;
    d.logdims[1] = 4'd9;
    mv = '0;
    for (int j = 0; j <= TEX_LOD_MAX; j++) mv |= MW'(j * 'h40) << (TEX_MIPOFF_BITS * j);
    d.mipoff = mv;
    return d;
  endfunction

  function automatic tex_dcrs_t mutate(tex_dcrs_t s);
    tex_dcrs_t     d;
    logic [MW-1:0] mv;
    d = s;
    if ($urandom_range(0, 2) == 0) d.baseaddr = $urandom;
    if ($urandom_range(0, 2) == 0) d.format   = 3'($urandom);
    if ($urandom_range(0, 2) == 0) d.filter   = 2'($urandom);
    if ($urandom_range(0, 2) == 0) d.wraps    = 4'($urandom);
    if ($urandom_range(0, 2) == 0) d.logdims  = 8'($urandom);
    mv = d.mipoff;
    for (int j = 0; j <= TEX_LOD_MAX; j++)
      if ($urandom_range(0, 3) == 0)
        mv = (mv & ~(MW'(20'hFFFFF) << (TEX_MIPOFF_BITS * j))) |
             (MW'($urandom & 32'hFFFFF) << (TEX_MIPOFF_BITS * j));
    d.mipoff = mv;
    return d;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tex_dcrs_t d1, d3, d4, dr;
    int stg, cnt, guard;

    for (int s = 0; s < NS; s++) m_sv[s] = 1'b0;
    m_cur   = 0;
    m_cur_v = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d_rst_wvalid", u), 32'(wv[u]),  32'd0);
      chk($sformatf("u%0d_rst_waddr", u),  32'(wa[u]),  32'd0);
      chk($sformatf("u%0d_rst_wdata", u),  wd[u],       32'd0);
      chk($sformatf("u%0d_rst_ready", u),  32'(rdy[u]), 32'd0);
      chk($sformatf("u%0d_rst_busy", u),   32'(bsy[u]), 32'd0);
      chk($sformatf("u%0d_rst_done", u),   32'(dn[u]),  32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    chk("u0_idle_ready", 32'(rdy[0]), 32'd1);
    chk("u1_idle_ready", 32'(rdy[1]), 32'd1);

    d1 = base_desc();
    txn(0, d1, 1'b0);                  // full programming
    txn(0, d1, 1'b0);                  // nothing changed
    d3 = d1;
    d3.format = 3'd3;
    txn(0, d3, 1'b0);                  // single FORMAT write
    d4 = mutate(d3);
    d4.baseaddr = 32'h2000;
    txn(1, d4, 1'b0);                  // new stage: STAGE + all fields
    txn(0, d3, 1'b0);                  // back to stage 0: STAGE only
    txn(0, d3, 1'b1);                  // forced rewrite

    // Abort a forced sequence after its third write on the back-to-back unit.
    build(0, d1, 1'b1);
    req_stage = '0;
    req_dcrs  = d1;
    req_force = 1'b1;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    cnt   = 0;
    guard = 0;
    while (cnt < 3 && guard < 40) begin
      @(posedge clk); #1;
      if (wv[0]) cnt++;
      guard++;
    end
    chk("u0_abort_three_writes", 32'(cnt), 32'd3);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("u%0d_abort_wvalid_%0d", u, c), 32'(wv[u]),  32'd0);
        chk($sformatf("u%0d_abort_busy_%0d", u, c),   32'(bsy[u]), 32'd0);
        chk($sformatf("u%0d_abort_done_%0d", u, c),   32'(dn[u]),  32'd0);
      end
    end
    reset = 1'b0;
    for (int s = 0; s < NS; s++) m_sv[s] = 1'b0;
    m_cur_v = 1'b0;
    @(posedge clk); #1;
    chk("u0_post_abort_ready", 32'(rdy[0]), 32'd1);
    txn(0, d3, 1'b0);                  // shadows gone: everything rewritten

    for (int t = 0; t < 30; t++) begin
      stg = $urandom_range(0, NS - 1);
      if (m_sv[stg]) dr = mutate(m_sh[stg]);
      else           dr = {$urandom, $urandom, $urandom, $urandom};
      txn(stg, dr, ($urandom_range(0, 7) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/vx_tex_dcr_master.md
Name: VX_tex_dcr_master

Overview:
- DCR bus initiator that programs the texture unit's per-stage DCR file from a complete stage descriptor.
- Accepts one descriptor per request and serialises it into DCR writes in a fixed order: STAGE, ADDR, FORMAT, FILTER, WRAP, LOGDIM, MIPOFF(0..LOD_MAX).
- Keeps a per-stage shadow copy and skips writes whose value is already programmed.
- Sits between the command processor/driver-side logic and the tex DCR slave.

Parameters:
INSTANCE_ID, "", trace tag.
NUM_STAGES, 1, number of texture stages shadowed; stage index width is CLOG2(NUM_STAGES), minimum 1.
GAP_CYCLES, 0, idle cycles inserted after each DCR write (0 means back-to-back writes).

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  descriptor valid.
req_ready  output  1  descriptor accepted when valid&&ready.
req_stage  input  `VX_TEX_STAGE_BITS  target stage.
req_dcrs  input  tex_dcrs_t  full stage descriptor.
req_force  input  1  write every register regardless of the shadow.
busy  output  1  request in flight.
done  output  1  one-cycle pulse when the sequence completes.
dcr_bus_if  VX_dcr_bus_if.master  -  write_valid, write_addr (`VX_DCR_ADDR_WIDTH), write_data (32).

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset values: write_valid=0, write_addr=0, write_data=0, done=0, busy=0, req_ready=0 while reset is high; all shadow_valid bits and cur_stage_valid cleared.
- FSM states: IDLE, ISSUE, GAP, FIN.
  - IDLE: req_ready=1.
  - On accept: latch stage and dcrs, compute a dirty mask over N = 6+`VX_TEX_LOD_MAX+1 items, go to ISSUE.
  - A mask of all zeros goes directly to FIN.
- Dirty rules:
  - STAGE item dirty if req_force, !cur_stage_valid, or req_stage != cur_stage.
  - Any other item dirty if req_force, !shadow_valid[req_stage], or its field differs from shadow[req_stage].
- ISSUE:
  - Each cycle emits exactly one registered write for the lowest-index set dirty bit, then clears that bit.
  - Clean items cost zero cycles (priority select).
  - After the write: GAP if GAP_CYCLES>0, else stay in ISSUE. When the mask empties, go to FIN.
- GAP: counts GAP_CYCLES cycles with write_valid=0, then returns to ISSUE (or FIN if the mask is empty).
- FIN:
  - done=1 for exactly one cycle.
  - shadow[stage] <= latched dcrs; shadow_valid[stage]=1; cur_stage <= stage; cur_stage_valid=1.
  - Return to IDLE. req_ready becomes 1 on the following cycle.
- Latency: accept-to-done = D*(1+GAP_CYCLES)+1 cycles, where D = number of dirty items. D=0 gives done one cycle after accept.
- write_data packing; all unused bits are zero:
  - STAGE: stage zero-extended.
  - ADDR: baseaddr[`TEX_ADDR_BITS-1:0].
  - FORMAT and FILTER: zero-extended.
  - WRAP: wraps[0] at [0+:`TEX_WRAP_BITS], wraps[1] at [16+:`TEX_WRAP_BITS].
  - LOGDIM: logdims[0] at [0+:`VX_TEX_LOD_BITS], logdims[1] at [16+:].
  - MIPOFF(j): mipoff[j] at `VX_DCR_TEX_MIPOFF(j).
- Addresses: `VX_DCR_TEX_STAGE, _ADDR, _FORMAT, _FILTER, _WRAP, _LOGDIM, _MIPOFF(j).
- The STAGE write always precedes field writes of the same request, because of the ordering.
- Handshake and boundaries:
  - req_ready=0 in every state except IDLE; inputs are ignored while busy.
  - busy=1 from the cycle after accept through FIN inclusive.
  - req_stage >= NUM_STAGES is truncated to the stage width.
  - Reset mid-sequence aborts immediately: no further writes, shadows invalidated, the next request writes everything.
  - The DCR bus has no backpressure; one write per cycle is legal.

Test Plan:
1. After reset, stage=0, force=0, baseaddr=0x1000, format=2, filter=1, wraps={1,2}, logdims={8,9}, mipoff[j]=j*0x40 -> N writes in order on N consecutive cycles; WRAP data=0x00020001, LOGDIM data=0x00090008; done at cycle N+1.
2. Resubmit the identical descriptor for stage 0 -> zero writes; done one cycle after accept.
3. Same stage with only format=3 changed -> exactly one write (`VX_DCR_TEX_FORMAT, 0x3); no STAGE write.
4. NUM_STAGES=2: program stage 1 with new values, then stage 0 unchanged -> the stage-0 request emits only STAGE(0); the stage-1 request emits STAGE(1) plus all fields.
5. GAP_CYCLES=2, force=1 -> each write is followed by 2 cycles of write_valid=0; done at 3N+1; req_ready stays low throughout.
6. Assert reset after the 3rd write of a full sequence, then resubmit the case-3 descriptor -> no writes during reset; afterwards all N writes are emitted (shadows invalidated).
